// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU with status flags, an iterative
// shift-add multiplier and a sticky halt state.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   op/a/b valid this cycle
//   in_ready   op accepted when in_valid & in_ready
//   opcode     4-bit operation select
//   a, b       WIDTH-bit operands
//   out_valid  result/flags valid
//   out_ready  consumer takes result when out_valid & out_ready
//   result     registered WIDTH-bit result
//   flags      {carry, overflow, negative, zero}, registered with result
//   halted     sticky, set after a HALT op is accepted
//
// Add/sub uses a grouped carry-lookahead adder: every GROUP bits form a
// lookahead block, and group carries ripple from one block to the next.
module alu_pipe #(
   parameter int WIDTH = 9,
   parameter int GROUP = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             halted
);

   localparam int NGRP = WIDTH / GROUP;
   localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOTA = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_PASA = 4'b0100;
   localparam logic [3:0] OP_SHL  = 4'b0101;
   localparam logic [3:0] OP_SHR  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_ADD2 = 4'b1000;
   localparam logic [3:0] OP_SUB2 = 4'b1001;
   localparam logic [3:0] OP_PASB = 4'b1010;
   localparam logic [3:0] OP_NOP  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HALTED} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [3:0]       flags_reg, flags_next;
   logic             out_valid_reg, out_valid_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH-1:0] mcand_reg, mcand_next;
   logic [WIDTH-1:0] mult_reg, mult_next;
   logic [CW-1:0]    count_reg, count_next;

   // ---------------- carry-lookahead add/sub ----------------
   logic             is_sub, add_cin, add_cout, add_ovf;
   logic [WIDTH-1:0] add_y, gen_bits, prp_bits, carry_bits, add_sum;
   logic [NGRP-1:0]  grp_g, grp_p;
   logic             chain_cy, bit_cy, bit_pall;

   // Subtraction is a + ~b + 1, so the carry-out reads as "no borrow".
   assign is_sub   = (opcode == OP_SUB) | (opcode == OP_SUB2);
   assign add_y    = is_sub ? ~b : b;
   assign add_cin  = is_sub;
   assign gen_bits = a & add_y;
   assign prp_bits = a ^ add_y;

   // Per-group generate/propagate, independent of the incoming carry.
   genvar gi;
   generate
      for (gi = 0; gi < NGRP; gi++) begin : g_grp
         logic grp_g_l, grp_p_l;
         always_comb begin
            grp_g_l = 1'b0;
            grp_p_l = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
               grp_g_l = gen_bits[gi*GROUP+k] | (prp_bits[gi*GROUP+k] & grp_g_l);
               grp_p_l = grp_p_l & prp_bits[gi*GROUP+k];
            end
         end
         assign grp_g[gi] = grp_g_l;
         assign grp_p[gi] = grp_p_l;
      end
   endgenerate

   // Bit carries inside a group are flat lookahead terms from the group's
   // carry-in; the group carry then ripples into the next group.
   always_comb begin
      carry_bits = '0;
      chain_cy   = add_cin;
      bit_cy     = 1'b0;
      bit_pall   = 1'b1;
      for (int gr = 0; gr < NGRP; gr++) begin
         for (int j = 0; j < GROUP; j++) begin
            bit_cy   = 1'b0;
            bit_pall = 1'b1;
            for (int k = j - 1; k >= 0; k--) begin
               bit_cy   = bit_cy | (bit_pall & gen_bits[gr*GROUP+k]);
               bit_pall = bit_pall & prp_bits[gr*GROUP+k];
            end
            carry_bits[gr*GROUP+j] = bit_cy | (bit_pall & chain_cy);
         end
         chain_cy = grp_g[gr] | (grp_p[gr] & chain_cy);
      end
   end

   assign add_cout = chain_cy;
   assign add_sum  = prp_bits ^ carry_bits;
   assign add_ovf  = (a[WIDTH-1] == add_y[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);

   // ---------------- single-cycle op result ----------------
   logic [WIDTH-1:0] op_res;
   logic             op_c, op_v;

   always_comb begin
      op_res = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      case (opcode)
         OP_AND:          op_res = a & b;
         OP_OR:           op_res = a | b;
         OP_NOTA:         op_res = ~a;
         OP_ADD, OP_ADD2,
         OP_SUB, OP_SUB2: begin
            op_res = add_sum;
            op_c   = add_cout;
            op_v   = add_ovf;
         end
         OP_PASA:         op_res = a;
         OP_SHL:          op_res = {a[WIDTH-2:0], 1'b0};
         OP_SHR:          op_res = {1'b0, a[WIDTH-1:1]};
         OP_PASB:         op_res = b;
         default:         op_res = '0;
      endcase
   end

   // ---------------- control ----------------
   logic             accept;
   logic [WIDTH-1:0] acc_step;

   assign in_ready = (state_reg == ST_IDLE) & (~out_valid_reg | out_ready);
   assign accept   = in_valid & in_ready;
   assign acc_step = acc_reg + (mult_reg[0] ? mcand_reg : '0);

   always_comb begin
      state_next     = state_reg;
      result_next    = result_reg;
      flags_next     = flags_reg;
      out_valid_next = out_valid_reg & ~out_ready;
      acc_next       = acc_reg;
      mcand_next     = mcand_reg;
      mult_next      = mult_reg;
      count_next     = count_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               case (opcode)
                  OP_MUL: begin
                     state_next = ST_MUL;
                     acc_next   = '0;
                     mcand_next = a;
                     mult_next  = b;
                     count_next = '0;
                  end
                  OP_HALT: state_next = ST_HALTED;
                  // Previous result/flags stay in their registers; just re-present them.
                  OP_NOP:  out_valid_next = 1'b1;
                  default: begin
                     result_next    = op_res;
                     flags_next     = {op_c, op_v, op_res[WIDTH-1], (op_res == '0)};
                     out_valid_next = 1'b1;
                  end
               endcase
            end
         end
         ST_MUL: begin
            acc_next   = acc_step;
            mcand_next = mcand_reg << 1;
            mult_next  = mult_reg >> 1;
            count_next = count_reg + CW'(1);
            if (count_reg == CW'(WIDTH - 1)) begin
               result_next    = acc_step;
               flags_next     = {2'b00, acc_step[WIDTH-1], (acc_step == '0)};
               out_valid_next = 1'b1;
               count_next     = '0;
               state_next     = ST_IDLE;
            end
         end
         default: ;  // ST_HALTED: only a reset leaves
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         result_reg    <= '0;
         flags_reg     <= '0;
         out_valid_reg <= 1'b0;
         acc_reg       <= '0;
         mcand_reg     <= '0;
         mult_reg      <= '0;
         count_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         result_reg    <= result_next;
         flags_reg     <= flags_next;
         out_valid_reg <= out_valid_next;
         acc_reg       <= acc_next;
         mcand_reg     <= mcand_next;
         mult_reg      <= mult_next;
         count_reg     <= count_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;
   assign halted    = (state_reg == ST_HALTED);

endmodule
